// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: arms on request, waits for a level/edge trigger, then gates decimated ADC samples into the capture FIFO.
// Latency: the FIFO write strobe and data are registered one clock after the sample-slot edge.
// Backpressure: fifo_full_i at a slot drops that sample and sets sticky overflow; with STOP_ON_FULL the capture ends there.
module adc_capture_ctrl #(
   parameter int DATA_WIDTH   = 10,
   parameter int CNT_WIDTH    = 16,
   parameter int OFFSET_WIDTH = 16,
   parameter int DEC_WIDTH    = 8,
   parameter bit STOP_ON_FULL = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    arm_i,
   input  logic                    abort_i,
   input  logic [1:0]              trig_mode_i,
   input  logic                    trig_wait_i,
   input  logic [OFFSET_WIDTH-1:0] offset_i,
   input  logic [CNT_WIDTH-1:0]    samples_i,
   input  logic [DEC_WIDTH-1:0]    decimate_i,
   input  logic                    trigger_i,
   input  logic [DATA_WIDTH-1:0]   adc_data_i,
   input  logic                    adc_or_i,
   input  logic                    fifo_full_i,
   output logic                    fifo_wr_en_o,
   output logic [DATA_WIDTH+1:0]   fifo_din_o,
   output logic                    armed_o,
   output logic                    capturing_o,
   output logic                    done_o,
   output logic                    overflow_o
);

   localparam logic [CNT_WIDTH-1:0]    CNT_ONE = CNT_WIDTH'(1);
   localparam logic [OFFSET_WIDTH-1:0] OFF_ONE = OFFSET_WIDTH'(1);
   localparam logic [DEC_WIDTH-1:0]    DEC_ONE = DEC_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_INACTIVE,
      S_ARMED,
      S_DELAY,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   // Latched configuration. trig_wait_i is only consulted on the arm edge
   // itself, so it needs no stored copy.
   logic [1:0]              r_mode;
   logic [OFFSET_WIDTH-1:0] r_offset;
   logic [CNT_WIDTH-1:0]    r_samples;
   logic [DEC_WIDTH-1:0]    r_decimate;

   logic                    r_trig_prev;
   logic [OFFSET_WIDTH-1:0] r_delay_cnt;
   logic [DEC_WIDTH-1:0]    r_dec_cnt;
   logic [CNT_WIDTH-1:0]    r_slot_cnt;
   logic                    r_wr_en;
   logic [DATA_WIDTH+1:0]   r_din;
   logic                    r_overflow;

   logic                    w_hit;
   logic                    w_slot;
   logic                    w_last;
   logic                    w_arm_ok;
   logic [CNT_WIDTH-1:0]    w_slot_cnt_nxt;

   // Trigger qualifier for the latched mode (level modes ignore history).
   always_comb begin
      w_hit = 1'b0;
      case (r_mode)
         2'b00:   w_hit = ~trigger_i;
         2'b01:   w_hit = trigger_i;
         2'b10:   w_hit = trigger_i & ~r_trig_prev;
         default: w_hit = ~trigger_i & r_trig_prev;
      endcase
   end

   assign w_arm_ok       = arm_i & ~abort_i & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_slot         = (r_state == S_CAPTURE) & (r_dec_cnt == '0);
   assign w_slot_cnt_nxt = r_slot_cnt + CNT_ONE;
   // A full FIFO at a slot still consumes the slot; it only ends the run when stopping on full.
   assign w_last         = w_slot & ((fifo_full_i & STOP_ON_FULL) | (w_slot_cnt_nxt == r_samples));

   // Next-state and status decode; abort overrides everything including a same-cycle arm.
   always_comb begin
      w_state_nxt = r_state;
      armed_o     = 1'b0;
      capturing_o = 1'b0;
      done_o      = 1'b0;
      if (abort_i) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (arm_i)
                  w_state_nxt = (~trig_mode_i[1] & trig_wait_i) ? S_WAIT_INACTIVE : S_ARMED;
            end
            S_WAIT_INACTIVE: begin
               if (~w_hit) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
               if (w_hit) begin
                  if (r_samples == '0)     w_state_nxt = S_DONE;
                  else if (r_offset == '0) w_state_nxt = S_CAPTURE;
                  else                     w_state_nxt = S_DELAY;
               end
            end
            S_DELAY: begin
               if (r_delay_cnt == '0) w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
               if (w_last) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
      armed_o     = (r_state == S_WAIT_INACTIVE) | (r_state == S_ARMED);
      capturing_o = (r_state == S_DELAY) | (r_state == S_CAPTURE);
      done_o      = (r_state == S_DONE);
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Config latch, delay/decimation/slot counters and the registered FIFO write port.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_trig_prev <= 1'b0;
         r_mode      <= '0;
         r_offset    <= '0;
         r_samples   <= '0;
         r_decimate  <= '0;
         r_delay_cnt <= '0;
         r_dec_cnt   <= '0;
         r_slot_cnt  <= '0;
         r_wr_en     <= 1'b0;
         r_din       <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_trig_prev <= trigger_i;
         r_wr_en     <= 1'b0;
         if (abort_i) begin
            r_overflow <= 1'b0;
         end else begin
            if (w_arm_ok) begin
               r_mode     <= trig_mode_i;
               r_offset   <= offset_i;
               r_samples  <= samples_i;
               r_decimate <= decimate_i;
               r_slot_cnt <= '0;
               r_overflow <= 1'b0;
            end
            case (r_state)
               S_ARMED: begin
                  if (w_hit) r_delay_cnt <= r_offset - OFF_ONE;
                  r_dec_cnt <= '0;
               end
               S_DELAY: begin
                  if (r_delay_cnt != '0) r_delay_cnt <= r_delay_cnt - OFF_ONE;
                  r_dec_cnt <= '0;
               end
               S_CAPTURE: begin
                  r_dec_cnt <= (r_dec_cnt == r_decimate) ? '0 : r_dec_cnt + DEC_ONE;
                  if (w_slot) begin
                     r_slot_cnt <= w_slot_cnt_nxt;
                     if (fifo_full_i) begin
                        r_overflow <= 1'b1;
                     end else begin
                        r_wr_en <= 1'b1;
                        r_din   <= {1'b1, adc_or_i, adc_data_i};
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign fifo_wr_en_o = r_wr_en;
   assign fifo_din_o   = r_din;
   assign overflow_o   = r_overflow;

endmodule
